// File: rtl/local_maxima_scan_ctrl.sv
// Raster-scan sequencer feeding 3x3 windows from a single-port pixel RAM to the
// neighbour comparator and writing one local-maximum bit per pixel to result RAM.
module local_maxima_scan_ctrl #(
    parameter int unsigned IMG_W  = 16,
    parameter int unsigned IMG_H  = 16,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                mem_rd,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [DATA_W-1:0]   cmp_in,
    output logic [8*DATA_W-1:0] cmp_n,
    output logic [7:0]          cmp_res,
    output logic                cmp_stb,
    input  logic                cmp_out,
    output logic                res_wr,
    output logic [ADDR_W-1:0]   res_addr,
    output logic                res_bit
);

    localparam int unsigned XW = $clog2(IMG_W);
    localparam int unsigned YW = $clog2(IMG_H);
    localparam int unsigned SW = 4;
    localparam logic [SW-1:0] LAST_SLOT = SW'(8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_PRESENT,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    // Slot 0 is the centre; slots 1..8 are neighbours in comparator order.
    function automatic int slot_dx(input logic [SW-1:0] s);
        case (s)
            4'd1, 4'd4, 4'd6: return -1;
            4'd3, 4'd5, 4'd8: return 1;
            default:          return 0;
        endcase
    endfunction

    function automatic int slot_dy(input logic [SW-1:0] s);
        case (s)
            4'd1, 4'd2, 4'd3: return -1;
            4'd6, 4'd7, 4'd8: return 1;
            default:          return 0;
        endcase
    endfunction

    function automatic logic slot_in_img(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                         input logic [SW-1:0] s);
        int nx;
        int ny;
        nx = int'(x) + slot_dx(s);
        ny = int'(y) + slot_dy(s);
        return (nx >= 0) && (nx < int'(IMG_W)) && (ny >= 0) && (ny < int'(IMG_H));
    endfunction

    function automatic logic [ADDR_W-1:0] slot_addr(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                                    input logic [SW-1:0] s);
        int nx;
        int ny;
        nx = int'(x) + slot_dx(s);
        ny = int'(y) + slot_dy(s);
        return ADDR_W'(ny * int'(IMG_W) + nx);
    endfunction

    state_t                    state_q, state_d;
    logic [SW-1:0]             slot_q, slot_d;
    logic [XW-1:0]             x_q, x_d;
    logic [YW-1:0]             y_q, y_d;
    logic                      start_en_q, start_en_d;
    logic [8:0][DATA_W-1:0]    win_q, win_d;
    logic [7:0]                cmp_res_q, cmp_res_d;
    logic                      res_bit_q, res_bit_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0]         mem_addr_q, mem_addr_d;
    logic                      cmp_stb_q, cmp_stb_d;
    logic                      res_wr_q, res_wr_d;
    logic [ADDR_W-1:0]         res_addr_q, res_addr_d;
    logic                      last_pix;
    logic [SW-1:0]             cap_slot;

    assign last_pix = (x_q == XW'(IMG_W - 1)) && (y_q == YW'(IMG_H - 1));

    // Next state, window capture and registered-output decode.
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        x_d        = x_q;
        y_d        = y_q;
        start_en_d = 1'b1;
        win_d      = win_q;
        cmp_res_d  = cmp_res_q;
        res_bit_d  = res_bit_q;
        cap_slot   = slot_q - SW'(1);

        case (state_q)
            S_IDLE: begin
                if (start && start_en_q) begin
                    state_d = S_FETCH;
                    slot_d  = '0;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            S_FETCH: begin
                // Read data returns one cycle late, so capture the previous slot.
                if (slot_q != '0) begin
                    win_d[cap_slot] = slot_in_img(x_q, y_q, cap_slot) ? mem_rdata : '0;
                end
                if (slot_q == LAST_SLOT) begin
                    state_d = S_CAPTURE;
                end else begin
                    slot_d = slot_q + SW'(1);
                end
            end
            S_CAPTURE: begin
                win_d[LAST_SLOT] = slot_in_img(x_q, y_q, LAST_SLOT) ? mem_rdata : '0;
                for (int k = 1; k <= 8; k++) begin
                    cmp_res_d[k-1] = slot_in_img(x_q, y_q, SW'(k));
                end
                state_d = S_PRESENT;
            end
            S_PRESENT: state_d = S_WAIT;
            S_WAIT: begin
                res_bit_d = cmp_out;
                state_d   = S_WRITE;
            end
            S_WRITE: begin
                if (last_pix) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_FETCH;
                    slot_d  = '0;
                    if (x_q == XW'(IMG_W - 1)) begin
                        x_d = '0;
                        y_d = y_q + YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        mem_rd_d   = (state_d == S_FETCH) && slot_in_img(x_d, y_d, slot_d);
        mem_addr_d = mem_rd_d ? slot_addr(x_d, y_d, slot_d) : '0;
        cmp_stb_d  = (state_d == S_PRESENT);
        res_wr_d   = (state_d == S_WRITE);
        res_addr_d = res_wr_d ? slot_addr(x_d, y_d, '0) : res_addr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            slot_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            start_en_q <= 1'b0;
            win_q      <= '0;
            cmp_res_q  <= '0;
            res_bit_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            cmp_stb_q  <= 1'b0;
            res_wr_q   <= 1'b0;
            res_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            x_q        <= x_d;
            y_q        <= y_d;
            start_en_q <= start_en_d;
            win_q      <= win_d;
            cmp_res_q  <= cmp_res_d;
            res_bit_q  <= res_bit_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            cmp_stb_q  <= cmp_stb_d;
            res_wr_q   <= res_wr_d;
            res_addr_q <= res_addr_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign cmp_in   = win_q[0];
    assign cmp_n    = win_q[8:1];
    assign cmp_res  = cmp_res_q;
    assign cmp_stb  = cmp_stb_q;
    assign res_wr   = res_wr_q;
    assign res_addr = res_addr_q;
    assign res_bit  = res_bit_q;

endmodule

// File: tb/tb_local_maxima_scan_ctrl.sv
// Bench for local_maxima_scan_ctrl on a 3x3 image: pixel RAM and comparator models,
// table of images with hand-computed result maps, per-cycle timeline checks.
module tb_local_maxima_scan_ctrl;

    localparam int W        = 3;
    localparam int H        = 3;
    localparam int NPIX     = W * H;
    localparam int SCAN_CYC = 13 * NPIX;
    localparam int NVEC     = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, mem_rd, cmp_stb, res_wr, res_bit;
    logic        cmp_out = 1'b0;
    logic [7:0]  mem_addr, res_addr, cmp_in, cmp_res;
    logic [7:0]  mem_rdata = 8'd0;
    logic [63:0] cmp_n;

    local_maxima_scan_ctrl #(.IMG_W(W), .IMG_H(H), .DATA_W(8), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .cmp_in(cmp_in), .cmp_n(cmp_n), .cmp_res(cmp_res), .cmp_stb(cmp_stb),
        .cmp_out(cmp_out), .res_wr(res_wr), .res_addr(res_addr), .res_bit(res_bit)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [71:0] img;       // pixel p in img[p*8 +: 8]
        logic [8:0]  exp_res;   // expected local-maximum bit per address
        logic        mid_start; // pulse start while busy
    } vec_t;

    vec_t        tbl [NVEC];
    logic [7:0]  pix [NPIX];
    logic [29:0] tr_ref [SCAN_CYC + 2];
    int          n_vec = 0;
    int          n_miss = 0;
    int          cur_v = -1;
    int          cur_cyc = 0;

    function automatic bit is_max(input logic [7:0] c, input logic [63:0] n, input logic [7:0] r);
        for (int k = 0; k < 8; k++) begin
            if (r[k] && (n[k*8 +: 8] > c)) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (mem_rd && (int'(mem_addr) < NPIX)) mem_rdata <= pix[int'(mem_addr)];
    end

    always @(posedge clk) begin
        if (cmp_stb) cmp_out <= is_max(cmp_in, cmp_n, cmp_res);
    end

    function automatic int dx_of(input int k);
        return (k == 1 || k == 4 || k == 6) ? -1 : ((k == 3 || k == 5 || k == 8) ? 1 : 0);
    endfunction

    function automatic int dy_of(input int k);
        return (k >= 1 && k <= 3) ? -1 : ((k >= 6) ? 1 : 0);
    endfunction

    function automatic bit inb(input int px, input int py, input int k);
        int nx;
        int ny;
        nx = px + dx_of(k);
        ny = py + dy_of(k);
        return (nx >= 0) && (nx < W) && (ny >= 0) && (ny < H);
    endfunction

    function automatic int nb_addr(input int px, input int py, input int k);
        return (py + dy_of(k)) * W + px + dx_of(k);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s (vec %0d cycle %0d): got %0h expected %0h", name, cur_v, cur_cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"}, 64'(busy), 0);
        chk({tag, ".done"}, 64'(done), 0);
        chk({tag, ".mem_rd"}, 64'(mem_rd), 0);
        chk({tag, ".mem_addr"}, 64'(mem_addr), 0);
        chk({tag, ".cmp_in"}, 64'(cmp_in), 0);
        chk({tag, ".cmp_n"}, cmp_n, 0);
        chk({tag, ".cmp_res"}, 64'(cmp_res), 0);
        chk({tag, ".cmp_stb"}, 64'(cmp_stb), 0);
        chk({tag, ".res_wr"}, 64'(res_wr), 0);
        chk({tag, ".res_addr"}, 64'(res_addr), 0);
        chk({tag, ".res_bit"}, 64'(res_bit), 0);
    endtask

    // One full scan started from IDLE; every cycle is checked against the expected timeline.
    task automatic run_scan(input int v);
        int          p, ph, px, py, rd_cnt, wr_cnt, done_cnt;
        logic        exp_rd;
        logic [7:0]  exp_flags, exp_nb;
        logic [29:0] cur;
        cur_v = v;
        for (int q = 0; q < NPIX; q++) pix[q] = tbl[v].img[q*8 +: 8];
        rd_cnt = 0;
        wr_cnt = 0;
        done_cnt = 0;
        start = 1'b1;
        for (int i = 1; i <= SCAN_CYC + 1; i++) begin
            tick();
            cur_cyc = i;
            start = tbl[v].mid_start && (i == 50);
            wr_cnt += int'(res_wr);
            done_cnt += int'(done);
            cur = {mem_rd, mem_addr, cmp_stb, res_wr, res_wr ? res_addr : 8'd0,
                   res_wr & res_bit, done, busy, cmp_stb ? cmp_res : 8'd0};
            if (v == 0) tr_ref[i] = cur;
            if (v == NVEC - 1) chk("trace_vs_first_scan", 64'(cur), 64'(tr_ref[i]));
            if (i <= SCAN_CYC) begin
                p  = (i - 1) / 13;
                ph = (i - 1) % 13;
                px = p % W;
                py = p / W;
                chk("busy", 64'(busy), 1);
                chk("done", 64'(done), 0);
                exp_rd = (ph < 9) && inb(px, py, ph);
                chk("mem_rd", 64'(mem_rd), 64'(exp_rd));
                if (exp_rd) chk("mem_addr", 64'(mem_addr), 64'(nb_addr(px, py, ph)));
                if (p == 0 && ph < 9) rd_cnt += int'(mem_rd);
                if (p == 0 && ph == 8) chk("corner_rd_count", 64'(rd_cnt), 4);
                chk("cmp_stb", 64'(cmp_stb), 64'(ph == 10));
                if (ph >= 10) begin
                    for (int k = 1; k <= 8; k++) exp_flags[k-1] = inb(px, py, k);
                    chk("cmp_res", 64'(cmp_res), 64'(exp_flags));
                    chk("cmp_in", 64'(cmp_in), 64'(pix[p]));
                    for (int k = 1; k <= 8; k++) begin
                        exp_nb = inb(px, py, k) ? pix[nb_addr(px, py, k)] : 8'd0;
                        chk("cmp_n", 64'(cmp_n[(k-1)*8 +: 8]), 64'(exp_nb));
                    end
                end
                if (p == 0 && ph == 10) chk("corner_cmp_res", 64'(cmp_res), 64'(8'hD0));
                if (p == 8 && ph == 10) chk("far_corner_cmp_res", 64'(cmp_res), 64'(8'h0B));
                chk("res_wr", 64'(res_wr), 64'(ph == 12));
                if (ph == 12) begin
                    chk("res_addr", 64'(res_addr), 64'(p));
                    chk("res_bit", 64'(res_bit), 64'(tbl[v].exp_res[p]));
                end
            end else begin
                chk("done_at_118", 64'(done), 1);
                chk("busy_with_done", 64'(busy), 1);
                chk("excl_mem_rd", 64'(mem_rd), 0);
                chk("excl_res_wr", 64'(res_wr), 0);
                chk("excl_cmp_stb", 64'(cmp_stb), 0);
            end
        end
        tick();
        cur_cyc = SCAN_CYC + 2;
        chk("busy_after_done", 64'(busy), 0);
        chk("done_one_cycle", 64'(done), 0);
        chk("res_wr_pulses", 64'(wr_cnt), NPIX);
        chk("done_pulses", 64'(done_cnt), 1);
    endtask

    initial begin
        tbl[0] = '{img: {8'd8, 8'd7, 8'd6, 8'd5, 8'd9, 8'd4, 8'd3, 8'd2, 8'd1},
                   exp_res: 9'h010, mid_start: 1'b0};
        tbl[1] = '{img: {9{8'd5}}, exp_res: 9'h1FF, mid_start: 1'b0};
        tbl[2] = '{img: {8'd9, 8'd1, 8'd9, 8'd1, 8'd1, 8'd1, 8'd9, 8'd1, 8'd9},
                   exp_res: 9'h145, mid_start: 1'b0};
        tbl[3] = '{img: {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0},
                   exp_res: 9'h100, mid_start: 1'b0};
        tbl[4] = '{img: {8'd8, 8'd7, 8'd6, 8'd5, 8'd9, 8'd4, 8'd3, 8'd2, 8'd1},
                   exp_res: 9'h010, mid_start: 1'b1};
        for (int q = 0; q < NPIX; q++) pix[q] = 8'd0;

        rst = 1'b1;
        start = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");

        // start coinciding with reset release must be dropped
        rst = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_at_release_ignored", 64'(busy), 0);
        tick();
        chk("still_idle", 64'(busy), 0);

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("first_rd", 64'(mem_rd), 1);
        chk("first_addr", 64'(mem_addr), 0);
        chk("first_busy", 64'(busy), 1);
        repeat (3) tick();
        #2 rst = 1'b1;
        #1 chk_all_zero("mid_fetch_reset");
        tick();
        rst = 1'b0;
        tick();

        for (int v = 0; v < NVEC; v++) run_scan(v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
